// File: rtl/sliding_window_3x3_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : sliding_window_3x3_pkg                                    |
// | Description : Shared constants and types for the 3x3 sliding window.    |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
package sliding_window_3x3_pkg;

   localparam int PIX_W_DEFAULT = 8;

   // Window positions, row-major, top-left = 1 ... bottom-right = 9
   localparam int WIN_TL = 1;
   localparam int WIN_TC = 2;
   localparam int WIN_TR = 3;
   localparam int WIN_ML = 4;
   localparam int WIN_MC = 5;
   localparam int WIN_MR = 6;
   localparam int WIN_BL = 7;
   localparam int WIN_BC = 8;
   localparam int WIN_BR = 9;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/sliding_window_3x3_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : sliding_window_3x3_if                                     |
// | Description : Pixel stream in, 3x3 window plus framing flags out.       |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
interface sliding_window_3x3_if
   import sliding_window_3x3_pkg::*;
#(
   parameter int PIX_W = PIX_W_DEFAULT
);
   logic             sof;
   logic             in_valid;
   logic [PIX_W-1:0] in_pixel;
   logic             en;
   logic             act;
   logic             frame_done;
   logic [PIX_W-1:0] sw_pixels1;
   logic [PIX_W-1:0] sw_pixels2;
   logic [PIX_W-1:0] sw_pixels3;
   logic [PIX_W-1:0] sw_pixels4;
   logic [PIX_W-1:0] sw_pixels5;
   logic [PIX_W-1:0] sw_pixels6;
   logic [PIX_W-1:0] sw_pixels7;
   logic [PIX_W-1:0] sw_pixels8;
   logic [PIX_W-1:0] sw_pixels9;

   // Pixel source / window consumer side
   modport master (
      output sof, in_valid, in_pixel,
      input  en, act, frame_done,
      input  sw_pixels1, sw_pixels2, sw_pixels3, sw_pixels4, sw_pixels5,
      input  sw_pixels6, sw_pixels7, sw_pixels8, sw_pixels9
   );

   // Window generator side
   modport slave (
      input  sof, in_valid, in_pixel,
      output en, act, frame_done,
      output sw_pixels1, sw_pixels2, sw_pixels3, sw_pixels4, sw_pixels5,
      output sw_pixels6, sw_pixels7, sw_pixels8, sw_pixels9
   );
endinterface
`default_nettype wire

// File: rtl/sliding_window_3x3_line_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : sliding_window_3x3_line_buffer                            |
// | Description : One image line of storage. Read returns the content held  |
// |               before this cycle's write, so a same-address read/write   |
// |               sees the old pixel.                                       |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
module sliding_window_3x3_line_buffer #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 8,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   // Contents are deliberately not reset; the window gating hides stale data
   logic [WIDTH-1:0] r_mem [0:DEPTH-1];

   assign rd_data = r_mem[rd_addr];

   // Write port: storage updates on the edge, after the read has been used
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end
endmodule
`default_nettype wire

// File: rtl/sliding_window_3x3.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : sliding_window_3x3                                        |
// | Description : Raster pixel stream to fully-inside 3x3 windows, one      |
// |               window one cycle after its bottom-right pixel arrives.    |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
module sliding_window_3x3
   import sliding_window_3x3_pkg::*;
#(
   parameter int PIX_W = PIX_W_DEFAULT,
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
)(
   input  logic                 clk,
   input  logic                 rst_n,
   sliding_window_3x3_if.slave  bus
);
   localparam int c_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int c_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
   localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_COL_W-1:0] r_col;
   logic [c_ROW_W-1:0] r_row;
   logic [c_COL_W-1:0] w_col;
   logic [c_ROW_W-1:0] w_row;
   logic               w_accept;
   logic               w_last;
   logic               w_win_ok;
   logic               w_act;
   logic [PIX_W-1:0]   w_tap1;
   logic [PIX_W-1:0]   w_tap2;
   logic [PIX_W-1:0]   r_win [1:9];
   logic               r_en;
   logic               r_frame_done;

   // A sof pixel is always taken and restarts the frame at (0,0)
   assign w_accept = bus.in_valid & (bus.sof | (r_state == RUN));
   assign w_col    = bus.sof ? '0 : r_col;
   assign w_row    = bus.sof ? '0 : r_row;
   assign w_last   = (w_row == c_ROW_LAST) && (w_col == c_COL_LAST);
   assign w_win_ok = (w_row >= c_ROW_W'(2)) && (w_col >= c_COL_W'(2));

   // lb1 holds row r-1, lb2 holds row r-2; lb1's old pixel ages into lb2
   sliding_window_3x3_line_buffer #(
      .DEPTH (IMG_W), .WIDTH (PIX_W), .AW (c_COL_W)
   ) u_lb1 (
      .clk     (clk),
      .wr_en   (w_accept),
      .wr_addr (w_col),
      .wr_data (bus.in_pixel),
      .rd_addr (w_col),
      .rd_data (w_tap1)
   );

   sliding_window_3x3_line_buffer #(
      .DEPTH (IMG_W), .WIDTH (PIX_W), .AW (c_COL_W)
   ) u_lb2 (
      .clk     (clk),
      .wr_en   (w_accept),
      .wr_addr (w_col),
      .wr_data (w_tap1),
      .rd_addr (w_col),
      .rd_data (w_tap2)
   );

   // Frame state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Frame state transitions: enter on sof, leave after the final pixel
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid && bus.sof) w_state_nxt = RUN;
         RUN:     if (w_accept && w_last)      w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Frame-active flag follows the state register, so it drops with frame_done
   always_comb begin
      w_act = (r_state == RUN);
   end

   // Raster position of the next expected pixel
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (w_last) begin
            r_col <= '0;
            r_row <= '0;
         end else if (w_col == c_COL_LAST) begin
            r_col <= '0;
            r_row <= w_row + 1'b1;
         end else begin
            r_col <= w_col + 1'b1;
            r_row <= w_row;
         end
      end
   end

   // Column shift register plus registered window / end-of-frame pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 1; i <= 9; i++) r_win[i] <= '0;
         r_en         <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_en         <= w_accept & w_win_ok;
         r_frame_done <= w_accept & w_last;
         if (w_accept) begin
            r_win[WIN_TL] <= r_win[WIN_TC];
            r_win[WIN_TC] <= r_win[WIN_TR];
            r_win[WIN_TR] <= w_tap2;
            r_win[WIN_ML] <= r_win[WIN_MC];
            r_win[WIN_MC] <= r_win[WIN_MR];
            r_win[WIN_MR] <= w_tap1;
            r_win[WIN_BL] <= r_win[WIN_BC];
            r_win[WIN_BC] <= r_win[WIN_BR];
            r_win[WIN_BR] <= bus.in_pixel;
         end
      end
   end

   assign bus.en         = r_en;
   assign bus.act        = w_act;
   assign bus.frame_done = r_frame_done;
   assign bus.sw_pixels1 = r_win[WIN_TL];
   assign bus.sw_pixels2 = r_win[WIN_TC];
   assign bus.sw_pixels3 = r_win[WIN_TR];
   assign bus.sw_pixels4 = r_win[WIN_ML];
   assign bus.sw_pixels5 = r_win[WIN_MC];
   assign bus.sw_pixels6 = r_win[WIN_MR];
   assign bus.sw_pixels7 = r_win[WIN_BL];
   assign bus.sw_pixels8 = r_win[WIN_BC];
   assign bus.sw_pixels9 = r_win[WIN_BR];
endmodule
`default_nettype wire
